// File: rtl/serial_shift_unit.sv
// serial_shift_unit: multi-cycle right shifter, one bit per clock, valid/ready on both sides.
// Optional rotate-right mode enabled by defining SERIAL_SHIFT_ROTATE_EN.
module serial_shift_unit #(
    parameter int WIDTH = 4,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] data;
    logic             arith;
    logic             fill;
    logic [AMT_W-1:0] k;

    assign k = (in_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : in_amt;

`ifdef SERIAL_SHIFT_ROTATE_EN
    logic rot;
    assign fill = rot ? data[0] : (arith & data[WIDTH-1]);
`else
    assign fill = arith & data[WIDTH-1];
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = !in_ready;
    assign out_data  = data;

    // Accept in IDLE, shift one bit per cycle in SHIFT, hold result in DONE until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            data  <= '0;
            arith <= 1'b0;
`ifdef SERIAL_SHIFT_ROTATE_EN
            rot   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    data  <= in_data;
                    cnt   <= k;
                    arith <= (in_mode == 2'b01);
`ifdef SERIAL_SHIFT_ROTATE_EN
                    rot   <= (in_mode == 2'b10);
`endif
                    state <= (k == '0) ? DONE : SHIFT;
                end
                SHIFT: begin
                    data  <= {fill, data[WIDTH-1:1]};
                    cnt   <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_shift_unit.sv
// tb_serial_shift_unit: scoreboard bench with randomized and directed requests for serial_shift_unit.
module tb_serial_shift_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic [2:0] in_amt = '0;
    logic [1:0] in_mode = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       busy;

    typedef struct {
        logic [3:0] d;
        int         t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   rdy_mode = 0;
    bit   mon_en = 0;

    serial_shift_unit #(.WIDTH(4), .AMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    function automatic int clamp_amt(input logic [2:0] a);
        return (a > 3'd4) ? 4 : int'(a);
    endfunction

    // Reference: whole-word shift by the clamped amount, computed with plain integer arithmetic.
    function automatic logic [3:0] model(input logic [3:0] d, input logic [2:0] a, input logic [1:0] m);
        int k = clamp_amt(a);
        int u = int'(d);
        int s = d[3] ? u - 16 : u;
`ifdef SERIAL_SHIFT_ROTATE_EN
        if (m == 2'b10) return 4'(((u >> k) | (u << (4 - k))) & 15);
`endif
        if (m == 2'b01) return 4'((s >>> k) & 15);
        return 4'((u >> k) & 15);
    endfunction

    // Consumer side: random backpressure, or forced low/high for directed phases.
    always @(negedge clk) begin
        if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = (rdy_mode == 2);
    end

    // Monitor: latency, stability under stall, result comparison and handshake invariants.
    bit         pv = 0;
    bit         phs = 0;
    logic [3:0] pd = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && !pv) begin
                if (q.size() == 0) chk(1'b0, "spurious_out_valid", 1, 0);
                else chk(cyc == q[0].t, "latency", cyc, q[0].t);
            end
            if (pv && !phs) chk(out_valid && out_data == pd, "stall_stable", int'(out_data), int'(pd));
            if (out_valid && out_ready && q.size() > 0) begin
                chk(out_data == q[0].d, "result", int'(out_data), int'(q[0].d));
                void'(q.pop_front());
            end
            if (in_ready || out_valid) chk(!(in_ready && out_valid), "ready_valid_exclusive", 1, 0);
            if (busy != !in_ready) chk(1'b0, "busy_vs_in_ready", int'(busy), int'(!in_ready));
        end
        pv  = out_valid;
        phs = out_valid && out_ready;
        pd  = out_data;
    end

    // Called at a negedge; waits for IDLE, presents the request for exactly one edge.
    task automatic send(input logic [3:0] d, input logic [2:0] a, input logic [1:0] m, input bit push);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk(1'b0, "in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        if (push) begin
            e.d = model(d, a, m);
            e.t = cyc + 1 + clamp_amt(a);
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        in_amt   = 3'($urandom);
        in_mode  = 2'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(q.size() == 0, "drain", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
        chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        chk(out_data == 4'b0000, "reset_out_data", int'(out_data), 0);
        mon_en = 1;

        send(4'b1010, 3'd1, 2'b01, 1);
        send(4'b1010, 3'd1, 2'b00, 1);
        send(4'b1010, 3'd0, 2'b01, 1);
        send(4'b1000, 3'd7, 2'b01, 1);
        send(4'b1000, 3'd7, 2'b00, 1);
        send(4'b1001, 3'd1, 2'b10, 1);
        send(4'b1011, 3'd2, 2'b11, 1);
        send(4'b0110, 3'd4, 2'b10, 1);
        drain();

        rdy_mode = 1;
        send(4'b0110, 3'd2, 2'b00, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(out_valid == 1'b1, "bp_out_valid", int'(out_valid), 1);
        repeat (5) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            in_amt   = 3'($urandom);
            in_mode  = 2'($urandom);
            @(negedge clk);
            chk(in_ready == 1'b0, "bp_in_ready_low", int'(in_ready), 0);
            chk(out_data == 4'b0001, "bp_out_data", int'(out_data), 1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk(in_ready == 1'b1, "bp_release_idle", int'(in_ready), 1);
        chk(out_valid == 1'b0, "bp_release_valid", int'(out_valid), 0);
        send(4'b1100, 3'd0, 2'b00, 1);
        rdy_mode = 0;
        drain();

        send(4'b1010, 3'd3, 2'b00, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk(in_ready == 1'b1, "midreset_in_ready", int'(in_ready), 1);
        chk(out_valid == 1'b0, "midreset_out_valid", int'(out_valid), 0);
        chk(out_data == 4'b0000, "midreset_out_data", int'(out_data), 0);
        chk(busy == 1'b0, "midreset_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        repeat (200) send(4'($urandom), 3'($urandom), 2'($urandom), 1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
